// File: rtl/alu_dispatch.sv
// Request FIFO feeding an external combinational ALU, with a single registered
// result stage under valid/ready handshakes on both sides.
module alu_dispatch #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             alu_available,
   output logic [3:0]       alu_operation,
   output logic [31:0]      alu_inp1,
   output logic [31:0]      alu_inp2,
   input  logic [31:0]      alu_outp,
   input  logic             alu_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic             out_zero,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag,
   output logic [15:0]      issue_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] LAST_LEGAL_OP = 4'h3;

   logic [3:0]       r_opMem  [DEPTH];
   logic [31:0]      r_aMem   [DEPTH];
   logic [31:0]      r_bMem   [DEPTH];
   logic [TAG_W-1:0] r_tagMem [DEPTH];

   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic             r_outValid;
   logic [31:0]      r_outResult;
   logic             r_outZero;
   logic             r_outErr;
   logic [TAG_W-1:0] r_outTag;
   logic [15:0]      r_issueCount;

   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_issue;
   logic             w_illegal;
   logic [3:0]       w_headOp;
   logic [31:0]      w_headA;
   logic [31:0]      w_headB;
   logic [TAG_W-1:0] w_headTag;

   assign w_empty   = (r_wrPtr == r_rdPtr);
   assign w_full    = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) && (r_wrPtr[AW] != r_rdPtr[AW]);
   // Gating with rst_n keeps the upstream from seeing a ready FIFO while held in reset.
   assign in_ready  = rst_n && !w_full;
   assign w_push    = in_valid && in_ready;
   assign w_issue   = !w_empty && (!r_outValid || out_ready);

   assign w_headOp  = r_opMem[r_rdPtr[AW-1:0]];
   assign w_headA   = r_aMem[r_rdPtr[AW-1:0]];
   assign w_headB   = r_bMem[r_rdPtr[AW-1:0]];
   assign w_headTag = r_tagMem[r_rdPtr[AW-1:0]];
   assign w_illegal = (w_headOp > LAST_LEGAL_OP);

   always_comb begin
      alu_available = 1'b0;
      alu_operation = 4'h0;
      alu_inp1      = 32'h0;
      alu_inp2      = 32'h0;
      if (w_issue) begin
         alu_available = 1'b1;
         alu_operation = w_headOp;
         alu_inp1      = w_headA;
         alu_inp2      = w_headB;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_opMem[r_wrPtr[AW-1:0]]  <= in_op;
         r_aMem[r_wrPtr[AW-1:0]]   <= in_a;
         r_bMem[r_wrPtr[AW-1:0]]   <= in_b;
         r_tagMem[r_wrPtr[AW-1:0]] <= in_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr      <= '0;
         r_rdPtr      <= '0;
         r_issueCount <= 16'h0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + (AW+1)'(1);
         end
         if (w_issue) begin
            r_rdPtr      <= r_rdPtr + (AW+1)'(1);
            r_issueCount <= r_issueCount + 16'd1;
         end
      end
   end

   // Illegal opcodes still consume a slot so ordering and throughput are unaffected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outValid  <= 1'b0;
         r_outResult <= 32'h0;
         r_outZero   <= 1'b0;
         r_outErr    <= 1'b0;
         r_outTag    <= '0;
      end else if (w_issue) begin
         r_outValid <= 1'b1;
         r_outTag   <= w_headTag;
         if (w_illegal) begin
            r_outResult <= 32'h0;
            r_outZero   <= 1'b0;
            r_outErr    <= 1'b1;
         end else begin
            r_outResult <= alu_outp;
            r_outZero   <= alu_zero;
            r_outErr    <= 1'b0;
         end
      end else if (r_outValid && out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   assign out_valid   = r_outValid;
   assign out_result  = r_outResult;
   assign out_zero    = r_outZero;
   assign out_err     = r_outErr;
   assign out_tag     = r_outTag;
   assign issue_count = r_issueCount;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed self-checking bench for alu_dispatch with a behavioural ALU attached
// to the dispatch port.
module tb_alu_dispatch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [3:0]  in_tag;
   logic        alu_available;
   logic [3:0]  alu_operation;
   logic [31:0] alu_inp1;
   logic [31:0] alu_inp2;
   logic [31:0] alu_outp;
   logic        alu_zero;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_zero;
   logic        out_err;
   logic [3:0]  out_tag;
   logic [15:0] issue_count;

   int tests = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_dispatch #(.DEPTH(4), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .alu_available(alu_available), .alu_operation(alu_operation),
      .alu_inp1(alu_inp1), .alu_inp2(alu_inp2),
      .alu_outp(alu_outp), .alu_zero(alu_zero),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero), .out_err(out_err), .out_tag(out_tag),
      .issue_count(issue_count)
   );

   // Illegal codes produce garbage with zero set so a missing error override is visible.
   always_comb begin
      alu_outp = 32'hDEADBEEF;
      alu_zero = 1'b1;
      case (alu_operation)
         4'h0: alu_outp = alu_inp1 + alu_inp2;
         4'h1: alu_outp = alu_inp1 - alu_inp2;
         4'h2: alu_outp = alu_inp1 & alu_inp2;
         4'h3: alu_outp = alu_inp1 | alu_inp2;
         default: ;
      endcase
      if (alu_operation <= 4'h3) alu_zero = (alu_outp == 32'h0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pushReq(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      tests++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready); end
      tests++; if (alu_available !== 1'b0) begin failures++; $display("[TB] FAIL reset_alu_avail: got %b, expected 0", alu_available); end
      tests++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
      tests++; if (issue_count !== 16'h0) begin failures++; $display("[TB] FAIL reset_count: got %h, expected 0000", issue_count); end
      step(); step();
      rst_n = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_in_ready: got %b, expected 1", in_ready); end
   endtask

   task automatic test_single_add();
      out_ready = 1'b1;
      pushReq(4'h0, 32'd5, 32'd7, 4'd3);
      tests++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_no_bypass: got %b, expected 0", out_valid); end
      tests++; if (alu_available !== 1'b1 || alu_inp1 !== 32'd5 || alu_inp2 !== 32'd7)
         begin failures++; $display("[TB] FAIL add_dispatch: got avail=%b a=%h b=%h, expected 1/5/7", alu_available, alu_inp1, alu_inp2); end
      step();
      tests++; if (out_valid !== 1'b1 || out_result !== 32'd12 || out_zero !== 1'b0 || out_tag !== 4'd3 || out_err !== 1'b0)
         begin failures++; $display("[TB] FAIL add_result: got v=%b r=%h z=%b t=%h e=%b, expected 1/0000000c/0/3/0", out_valid, out_result, out_zero, out_tag, out_err); end
      step();
      tests++; if (out_valid !== 1'b0 || out_result !== 32'd12)
         begin failures++; $display("[TB] FAIL add_clear_hold: got v=%b r=%h, expected 0/0000000c", out_valid, out_result); end
   endtask

   task automatic test_sub();
      pushReq(4'h1, 32'h1234, 32'h1234, 4'd1);
      step();
      tests++; if (out_valid !== 1'b1 || out_result !== 32'h0 || out_zero !== 1'b1)
         begin failures++; $display("[TB] FAIL sub_equal: got v=%b r=%h z=%b, expected 1/00000000/1", out_valid, out_result, out_zero); end
      pushReq(4'h1, 32'd9, 32'd4, 4'd2);
      step();
      tests++; if (out_valid !== 1'b1 || out_result !== 32'd5 || out_zero !== 1'b0 || out_tag !== 4'd2)
         begin failures++; $display("[TB] FAIL sub_diff: got v=%b r=%h z=%b t=%h, expected 1/00000005/0/2", out_valid, out_result, out_zero, out_tag); end
      step();
      tests++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL sub_drain: got %b, expected 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [3:0]  ops  [5] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h0};
      logic [31:0] as   [5] = '{32'd100, 32'd50, 32'h0000F0F0, 32'h00000F00, 32'hFFFFFFFF};
      logic [31:0] bs   [5] = '{32'd23, 32'd8, 32'h0000FF00, 32'h000000F0, 32'h00000001};
      logic [31:0] exps [5] = '{32'd123, 32'd42, 32'h0000F000, 32'h00000FF0, 32'h00000000};
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tests++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_%0d: got %b, expected 1", i, in_ready); end
         in_valid = 1'b1; in_op = ops[i]; in_a = as[i]; in_b = bs[i]; in_tag = 4'(i);
         step();
      end
      in_valid = 1'b0;
      tests++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_full: got %b, expected 0", in_ready); end
      tests++; if (out_valid !== 1'b1 || out_result !== 32'd123 || out_tag !== 4'd0)
         begin failures++; $display("[TB] FAIL bp_held: got v=%b r=%h t=%h, expected 1/0000007b/0", out_valid, out_result, out_tag); end
      tests++; if (alu_available !== 1'b0 || alu_inp1 !== 32'h0 || alu_operation !== 4'h0)
         begin failures++; $display("[TB] FAIL bp_idle_alu: got avail=%b a=%h op=%h, expected 0/0/0", alu_available, alu_inp1, alu_operation); end
      pushReq(4'h0, 32'd777, 32'd0, 4'd9);
      step();
      tests++; if (out_result !== 32'd123 || out_tag !== 4'd0 || out_valid !== 1'b1)
         begin failures++; $display("[TB] FAIL bp_stable: got v=%b r=%h t=%h, expected 1/0000007b/0", out_valid, out_result, out_tag); end
      out_ready = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_indep: got %b, expected 0", in_ready); end
      for (int j = 1; j < 5; j++) begin
         step();
         tests++; if (out_valid !== 1'b1 || out_result !== exps[j] || out_tag !== 4'(j))
            begin failures++; $display("[TB] FAIL bp_drain_%0d: got v=%b r=%h t=%h, expected 1/%h/%0d", j, out_valid, out_result, out_tag, exps[j], j); end
      end
      tests++; if (out_zero !== 1'b1) begin failures++; $display("[TB] FAIL bp_wrap_zero: got %b, expected 1", out_zero); end
      step();
      tests++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_no_extra: got %b, expected 0", out_valid); end
   endtask

   task automatic test_illegal();
      tests++; if (issue_count !== 16'd8) begin failures++; $display("[TB] FAIL ill_count_before: got %0d, expected 8", issue_count); end
      pushReq(4'h9, 32'd3, 32'd4, 4'd5);
      pushReq(4'h0, 32'd3, 32'd4, 4'd6);
      tests++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_result !== 32'h0 || out_zero !== 1'b0 || out_tag !== 4'd5)
         begin failures++; $display("[TB] FAIL ill_result: got v=%b e=%b r=%h z=%b t=%h, expected 1/1/0/0/5", out_valid, out_err, out_result, out_zero, out_tag); end
      step();
      tests++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_result !== 32'd7 || out_tag !== 4'd6)
         begin failures++; $display("[TB] FAIL ill_next: got v=%b e=%b r=%h t=%h, expected 1/0/00000007/6", out_valid, out_err, out_result, out_tag); end
      tests++; if (issue_count !== 16'd10) begin failures++; $display("[TB] FAIL ill_count_after: got %0d, expected 10", issue_count); end
      step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      pushReq(4'h0, 32'd1, 32'd1, 4'd1);
      pushReq(4'h0, 32'd2, 32'd2, 4'd2);
      pushReq(4'h0, 32'd3, 32'd3, 4'd3);
      pushReq(4'h0, 32'd4, 32'd4, 4'd4);
      tests++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_setup: got %b, expected 1", out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 4'd0 || out_err !== 1'b0 || out_zero !== 1'b0)
         begin failures++; $display("[TB] FAIL mid_async_clear: got v=%b r=%h t=%h e=%b z=%b, expected all 0", out_valid, out_result, out_tag, out_err, out_zero); end
      tests++; if (issue_count !== 16'h0 || in_ready !== 1'b0 || alu_available !== 1'b0)
         begin failures++; $display("[TB] FAIL mid_async_ctrl: got cnt=%h rdy=%b avail=%b, expected 0/0/0", issue_count, in_ready, alu_available); end
      step(); step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      pushReq(4'h2, 32'h000000F0, 32'h0000003C, 4'd7);
      tests++; if (alu_available !== 1'b1 || alu_inp1 !== 32'h000000F0 || out_valid !== 1'b0)
         begin failures++; $display("[TB] FAIL mid_first_push: got avail=%b a=%h v=%b, expected 1/000000f0/0", alu_available, alu_inp1, out_valid); end
      step();
      tests++; if (out_valid !== 1'b1 || out_result !== 32'h00000030 || out_tag !== 4'd7)
         begin failures++; $display("[TB] FAIL mid_no_stale: got v=%b r=%h t=%h, expected 1/00000030/7", out_valid, out_result, out_tag); end
      step();
      tests++; if (out_valid !== 1'b0 || issue_count !== 16'd1)
         begin failures++; $display("[TB] FAIL mid_drained: got v=%b cnt=%0d, expected 0/1", out_valid, issue_count); end
   endtask

   task automatic test_back_to_back_wrap();
      int n = 0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b1; in_op = 4'h0; in_a = 32'd1; in_b = 32'd2; in_tag = 4'd1;
      while (issue_count !== 16'hFFFF && n < 70000) begin
         step();
         n++;
      end
      tests++; if (n !== 65536) begin failures++; $display("[TB] FAIL wrap_rate: got %0d cycles, expected 65536", n); end
      step();
      tests++; if (issue_count !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_count: got %h, expected 0000", issue_count); end
      tests++; if (out_valid !== 1'b1 || out_result !== 32'd3)
         begin failures++; $display("[TB] FAIL wrap_stream: got v=%b r=%h, expected 1/00000003", out_valid, out_result); end
      in_valid = 1'b0;
      step(); step();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_op = 4'h0; in_a = 32'h0; in_b = 32'h0; in_tag = 4'h0;
      out_ready = 1'b0;
      test_reset();
      test_single_add();
      test_sub();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      test_back_to_back_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
